// File: rtl/riscv_aes_writeback_if.sv
// riscv_aes_writeback_if
// Data-memory request/grant/rvalid port between the AES writeback unit and the
// core's data-memory interface.
//   master : the writeback unit (drives req/addr/we/be/wdata, receives gnt/rvalid)
//   slave  : the memory side
interface riscv_aes_writeback_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      data_req_o;
    logic                      data_gnt_i;
    logic                      data_rvalid_i;
    logic [DATA_WIDTH-1:0]     data_addr_o;
    logic                      data_we_o;
    logic [DATA_WIDTH/8-1:0]   data_be_o;
    logic [DATA_WIDTH-1:0]     data_wdata_o;

    modport master (
        output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i
    );

    modport slave (
        input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i
    );
endinterface

// File: rtl/riscv_aes_writeback.sv
// riscv_aes_writeback
// Stores a 128-bit AES result to data memory as four sequential word writes
// starting at a word-aligned base address, then pulses done_o.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   result_valid_i    : AES result available (held by producer until accepted)
//   result_i          : 128-bit result, word k at [32k+31:32k]
//   wb_addr_i         : writeback base address, low two bits ignored
//   result_ready_o    : unit idle, result will be accepted this cycle if valid
//   busy_o            : high in every state other than IDLE
//   done_o            : one-cycle pulse after the last write response
//   mem               : data-memory request/grant/rvalid port (master side)
// All outputs are decoded from registered state only.
module riscv_aes_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                result_valid_i,
    input  logic [DATA_WIDTH*NUM_WORDS-1:0]     result_i,
    input  logic [DATA_WIDTH-1:0]               wb_addr_i,
    output logic                                result_ready_o,
    output logic                                busy_o,
    output logic                                done_o,
    riscv_aes_writeback_if.master               mem
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                           state_reg, state_next;
    logic [1:0]                       cnt_reg, cnt_next;
    logic [DATA_WIDTH*NUM_WORDS-1:0]  buf_reg, buf_next;
    logic [DATA_WIDTH-1:0]            base_reg, base_next;

    // Word view of the latched result so the counter can select one directly.
    logic [DATA_WIDTH-1:0] word_sel [NUM_WORDS];

    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_words
            assign word_sel[gi] = buf_reg[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Byte offset of the current word; the add wraps modulo 2^DATA_WIDTH.
    logic [DATA_WIDTH-1:0] word_addr;
    assign word_addr = base_reg + {{(DATA_WIDTH-4){1'b0}}, cnt_reg, 2'b00};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            buf_reg   <= '0;
            base_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            buf_reg   <= buf_next;
            base_reg  <= base_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        buf_next   = buf_reg;
        base_next  = base_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (result_valid_i) begin
                    buf_next   = result_i;
                    // Writes are always word-aligned.
                    base_next  = wb_addr_i & ~{{(DATA_WIDTH-2){1'b0}}, 2'b11};
                    cnt_next   = 2'd0;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (mem.data_gnt_i) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem.data_rvalid_i) begin
                    if (cnt_reg == 2'(NUM_WORDS-1)) begin
                        state_next = S_DONE;
                    end else begin
                        cnt_next   = cnt_reg + 2'd1;
                        state_next = S_REQ;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        result_ready_o   = (state_reg == S_IDLE);
        busy_o           = (state_reg != S_IDLE);
        done_o           = (state_reg == S_DONE);
        mem.data_req_o   = (state_reg == S_REQ);
        mem.data_we_o    = 1'b0;
        mem.data_be_o    = '0;
        mem.data_addr_o  = '0;
        mem.data_wdata_o = '0;
        if (state_reg == S_REQ) begin
            mem.data_we_o    = 1'b1;
            mem.data_be_o    = '1;
            mem.data_addr_o  = word_addr;
            mem.data_wdata_o = word_sel[cnt_reg];
        end
    end

endmodule

// File: tb/tb_riscv_aes_writeback.sv
// Directed testbench for riscv_aes_writeback.
module tb_riscv_aes_writeback;

    logic         clk = 1'b0;
    logic         rst;
    logic         result_valid_i;
    logic [127:0] result_i;
    logic [31:0]  wb_addr_i;
    logic         result_ready_o;
    logic         busy_o;
    logic         done_o;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    riscv_aes_writeback_if #(.DATA_WIDTH(32)) mem_if ();

    riscv_aes_writeback #(
        .DATA_WIDTH (32),
        .NUM_WORDS  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .result_valid_i (result_valid_i),
        .result_i       (result_i),
        .wb_addr_i      (wb_addr_i),
        .result_ready_o (result_ready_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .mem            (mem_if)
    );

    always #5 clk = ~clk;

    // Count completion pulses mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (done_o === 1'b1) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic [31:0] addr, input logic [31:0] data);
        chk({tag, "_req"},   32'(mem_if.data_req_o),   32'd1);
        chk({tag, "_addr"},  mem_if.data_addr_o,       addr);
        chk({tag, "_wdata"}, mem_if.data_wdata_o,      data);
        chk({tag, "_we"},    32'(mem_if.data_we_o),    32'd1);
        chk({tag, "_be"},    32'(mem_if.data_be_o),    32'hF);
        chk({tag, "_busy"},  32'(busy_o),              32'd1);
        chk({tag, "_ready"}, 32'(result_ready_o),      32'd0);
        chk({tag, "_done"},  32'(done_o),              32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 32'(result_ready_o),      32'd1);
        chk({tag, "_busy"},  32'(busy_o),              32'd0);
        chk({tag, "_done"},  32'(done_o),              32'd0);
        chk({tag, "_req"},   32'(mem_if.data_req_o),   32'd0);
        chk({tag, "_we"},    32'(mem_if.data_we_o),    32'd0);
        chk({tag, "_be"},    32'(mem_if.data_be_o),    32'd0);
        chk({tag, "_addr"},  mem_if.data_addr_o,       32'd0);
        chk({tag, "_wdata"}, mem_if.data_wdata_o,      32'd0);
    endtask

    // Entered in the REQ cycle of a word; leaves in the cycle after its rvalid.
    task automatic do_word(input string tag, input logic [31:0] addr,
                           input logic [31:0] data, input int stall);
        chk_req(tag, addr, data);
        for (int i = 0; i < stall; i++) begin
            mem_if.data_gnt_i = 1'b0;
            step();
            chk_req({tag, "_stall"}, addr, data);
        end
        mem_if.data_gnt_i = 1'b1;
        step();
        mem_if.data_gnt_i = 1'b0;
        chk({tag, "_wait_req"},  32'(mem_if.data_req_o), 32'd0);
        chk({tag, "_wait_addr"}, mem_if.data_addr_o,     32'd0);
        chk({tag, "_wait_busy"}, 32'(busy_o),            32'd1);
        mem_if.data_rvalid_i = 1'b1;
        step();
        mem_if.data_rvalid_i = 1'b0;
    endtask

    // Presents a result in an IDLE cycle; returns in cycle 1 (first REQ).
    task automatic accept(input string tag, input logic [127:0] res,
                          input logic [31:0] addr, input bit hold);
        result_i       = res;
        wb_addr_i      = addr;
        result_valid_i = 1'b1;
        chk({tag, "_accept_ready"}, 32'(result_ready_o), 32'd1);
        step();
        if (!hold) result_valid_i = 1'b0;
    endtask

    // Entered in the cycle the done pulse is expected.
    task automatic finish(input string tag);
        chk({tag, "_done"},       32'(done_o),             32'd1);
        chk({tag, "_done_busy"},  32'(busy_o),             32'd1);
        chk({tag, "_done_req"},   32'(mem_if.data_req_o),  32'd0);
        chk({tag, "_done_ready"}, 32'(result_ready_o),     32'd0);
        step();
        chk({tag, "_after_done"},  32'(done_o),            32'd0);
        chk({tag, "_after_ready"}, 32'(result_ready_o),    32'd1);
    endtask

    initial begin
        rst                  = 1'b1;
        result_valid_i       = 1'b0;
        result_i             = '0;
        wb_addr_i            = '0;
        mem_if.data_gnt_i    = 1'b0;
        mem_if.data_rvalid_i = 1'b0;

        // Reset state
        step();
        step();
        chk_idle("reset");
        rst = 1'b0;
        step();
        chk_idle("post_reset");

        // Spurious handshakes while idle
        mem_if.data_gnt_i = 1'b1;
        step();
        mem_if.data_gnt_i = 1'b0;
        chk_idle("spur_gnt");
        mem_if.data_rvalid_i = 1'b1;
        step();
        mem_if.data_rvalid_i = 1'b0;
        chk_idle("spur_rvalid");
        step();
        chk_idle("spur_settle");

        // Basic: done in cycle 9
        accept("basic", 128'h33333333_22222222_11111111_00000000, 32'h0000_1000, 1'b0);
        do_word("basic_w0", 32'h0000_1000, 32'h00000000, 0);
        do_word("basic_w1", 32'h0000_1004, 32'h11111111, 0);
        do_word("basic_w2", 32'h0000_1008, 32'h22222222, 0);
        do_word("basic_w3", 32'h0000_100C, 32'h33333333, 0);
        finish("basic");
        chk_idle("basic_idle");

        // Grant stall of 3 cycles on word 1: done in cycle 12
        accept("gstall", 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 32'h0000_1000, 1'b0);
        do_word("gstall_w0", 32'h0000_1000, 32'hAAAAAAAA, 0);
        do_word("gstall_w1", 32'h0000_1004, 32'hBBBBBBBB, 3);
        do_word("gstall_w2", 32'h0000_1008, 32'hCCCCCCCC, 0);
        do_word("gstall_w3", 32'h0000_100C, 32'hDDDDDDDD, 0);
        finish("gstall");

        // Reset while word 2 is in REQ
        accept("rstmid", 128'h01020304_05060708_090A0B0C_0D0E0F10, 32'h0000_4000, 1'b0);
        do_word("rstmid_w0", 32'h0000_4000, 32'h0D0E0F10, 0);
        do_word("rstmid_w1", 32'h0000_4004, 32'h090A0B0C, 0);
        chk_req("rstmid_w2", 32'h0000_4008, 32'h05060708);
        mem_if.data_gnt_i = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_if.data_gnt_i = 1'b0;
        chk_idle("rstmid_after");
        mem_if.data_rvalid_i = 1'b1;
        step();
        mem_if.data_rvalid_i = 1'b0;
        chk_idle("rstmid_stray_rvalid");
        step();
        chk_idle("rstmid_settle");
        chk("rstmid_done_count", 32'(done_cnt), 32'd2);

        // Unaligned base wrapping past the top of the address space
        accept("wrap", 128'hCAFEF00D_0BADBEEF_12345678_DEADBEEF, 32'hFFFF_FFFB, 1'b0);
        do_word("wrap_w0", 32'hFFFF_FFF8, 32'hDEADBEEF, 0);
        do_word("wrap_w1", 32'hFFFF_FFFC, 32'h12345678, 0);
        do_word("wrap_w2", 32'h0000_0000, 32'h0BADBEEF, 0);
        do_word("wrap_w3", 32'h0000_0004, 32'hCAFEF00D, 0);
        finish("wrap");

        // Back-to-back: second result held valid throughout the first transfer
        accept("b2b_a", 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, 32'h0000_2000, 1'b1);
        result_i  = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
        wb_addr_i = 32'h0000_3002;
        do_word("b2b_a_w0", 32'h0000_2000, 32'hA0A0A0A0, 0);
        do_word("b2b_a_w1", 32'h0000_2004, 32'hA1A1A1A1, 0);
        do_word("b2b_a_w2", 32'h0000_2008, 32'hA2A2A2A2, 0);
        do_word("b2b_a_w3", 32'h0000_200C, 32'hA3A3A3A3, 0);
        finish("b2b_a");
        // Cycle 10: held result is accepted at the end of this cycle.
        step();
        result_valid_i = 1'b0;
        do_word("b2b_b_w0", 32'h0000_3000, 32'hB0B0B0B0, 0);
        do_word("b2b_b_w1", 32'h0000_3004, 32'hB1B1B1B1, 0);
        do_word("b2b_b_w2", 32'h0000_3008, 32'hB2B2B2B2, 0);
        do_word("b2b_b_w3", 32'h0000_300C, 32'hB3B3B3B3, 0);
        finish("b2b_b");
        chk_idle("b2b_idle");

        step();
        chk("total_done_count", 32'(done_cnt), 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
